// File: rtl/dma_burst_sequencer_if.sv
// Command and control bundle between the DMA burst sequencer and its neighbours.
// DMA_SEQ_ABORT_EN adds the iAbort/oAborted pair.
interface dma_burst_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              iStart;
  logic [ADDR_W-1:0] iRM_startaddr;
  logic [ADDR_W-1:0] iWM_startaddr;
  logic [ADDR_W-1:0] iLength;
  logic              oRM_cmd_valid;
  logic              iRM_cmd_ready;
  logic [ADDR_W-1:0] oRM_cmd_addr;
  logic [ADDR_W-1:0] oRM_cmd_len;
  logic              oWM_cmd_valid;
  logic              iWM_cmd_ready;
  logic [ADDR_W-1:0] oWM_cmd_addr;
  logic [ADDR_W-1:0] oWM_cmd_len;
  logic              iWM_burst_done;
  logic              oBusy;
  logic              oWM_done;
`ifdef DMA_SEQ_ABORT_EN
  logic              iAbort;
  logic              oAborted;

  modport master (
    input  iStart, iRM_startaddr, iWM_startaddr, iLength,
    input  iRM_cmd_ready, iWM_cmd_ready, iWM_burst_done, iAbort,
    output oRM_cmd_valid, oRM_cmd_addr, oRM_cmd_len,
    output oWM_cmd_valid, oWM_cmd_addr, oWM_cmd_len,
    output oBusy, oWM_done, oAborted
  );

  modport slave (
    output iStart, iRM_startaddr, iWM_startaddr, iLength,
    output iRM_cmd_ready, iWM_cmd_ready, iWM_burst_done, iAbort,
    input  oRM_cmd_valid, oRM_cmd_addr, oRM_cmd_len,
    input  oWM_cmd_valid, oWM_cmd_addr, oWM_cmd_len,
    input  oBusy, oWM_done, oAborted
  );
`else
  modport master (
    input  iStart, iRM_startaddr, iWM_startaddr, iLength,
    input  iRM_cmd_ready, iWM_cmd_ready, iWM_burst_done,
    output oRM_cmd_valid, oRM_cmd_addr, oRM_cmd_len,
    output oWM_cmd_valid, oWM_cmd_addr, oWM_cmd_len,
    output oBusy, oWM_done
  );

  modport slave (
    output iStart, iRM_startaddr, iWM_startaddr, iLength,
    output iRM_cmd_ready, iWM_cmd_ready, iWM_burst_done,
    input  oRM_cmd_valid, oRM_cmd_addr, oRM_cmd_len,
    input  oWM_cmd_valid, oWM_cmd_addr, oWM_cmd_len,
    input  oBusy, oWM_done
  );
`endif
endinterface

// File: rtl/dma_burst_sequencer.sv
// Splits one DMA transfer into bursts of at most MAX_BURST bytes and issues RM/WM command pairs.
// Optional abort support is enabled by defining DMA_SEQ_ABORT_EN.
module dma_burst_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  dma_burst_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LP_MAX   = ADDR_W'(MAX_BURST);
  localparam logic [ADDR_W-1:0] LP_WMASK = ~(ADDR_W'(3));

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD_CMD, S_WR_CMD, S_WAIT, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_start_q;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr, r_rem, r_blen;
  logic              r_rm_valid, r_wm_valid, r_busy, r_done;

  logic              w_start_edge, w_rm_acc, w_wm_acc, w_burst_done;
  logic              w_abort_cmd, w_abort_wait;
  logic [ADDR_W-1:0] w_rem_dec, w_blen_src, w_blen_calc;

  assign w_start_edge = bus.iStart & ~r_start_q;
  assign w_rm_acc     = r_rm_valid & bus.iRM_cmd_ready;
  assign w_wm_acc     = r_wm_valid & bus.iWM_cmd_ready;
  assign w_burst_done = (r_state == S_WAIT) & bus.iWM_burst_done;
  assign w_rem_dec    = r_rem - r_blen;
  // Next burst length comes from the post-burst remainder in WAIT, else from the loaded count
  assign w_blen_src   = (r_state == S_WAIT) ? w_rem_dec : r_rem;
  assign w_blen_calc  = (w_blen_src > LP_MAX) ? LP_MAX : w_blen_src;

`ifdef DMA_SEQ_ABORT_EN
  logic r_abort_pend, r_aborted;

  assign w_abort_cmd  = bus.iAbort;
  assign w_abort_wait = r_abort_pend | bus.iAbort;

  // Abort in WAIT is remembered until the in-flight burst completes
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      if (r_state == S_IDLE)
        r_abort_pend <= 1'b0;
      else if (r_state == S_WAIT && bus.iAbort)
        r_abort_pend <= 1'b1;

      if (r_state == S_IDLE && w_start_edge)
        r_aborted <= 1'b0;
      else if (((r_state == S_RD_CMD || r_state == S_WR_CMD) && bus.iAbort) ||
               (w_burst_done && w_abort_wait))
        r_aborted <= 1'b1;
    end
  end

  assign bus.oAborted = r_aborted;
`else
  assign w_abort_cmd  = 1'b0;
  assign w_abort_wait = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_start_edge) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = (r_rem == '0) ? S_DONE : S_RD_CMD;
      S_RD_CMD: begin
        if (w_abort_cmd)   w_state_nxt = S_DONE;
        else if (w_rm_acc) w_state_nxt = S_WR_CMD;
      end
      S_WR_CMD: begin
        if (w_abort_cmd)   w_state_nxt = S_DONE;
        else if (w_wm_acc) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.iWM_burst_done)
          w_state_nxt = (w_rem_dec == '0 || w_abort_wait) ? S_DONE : S_RD_CMD;
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_rm_valid <= 1'b0;
      r_wm_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rm_valid <= (w_state_nxt == S_RD_CMD);
      r_wm_valid <= (w_state_nxt == S_WR_CMD);
      r_busy     <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RD_CMD) ||
                    (w_state_nxt == S_WR_CMD) || (w_state_nxt == S_WAIT);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_start_q <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_rem     <= '0;
      r_blen    <= '0;
    end else begin
      r_start_q <= bus.iStart;
      if (r_state == S_IDLE && w_start_edge) begin
        r_rd_addr <= bus.iRM_startaddr;
        r_wr_addr <= bus.iWM_startaddr;
        r_rem     <= bus.iLength & LP_WMASK;
      end
      if (r_state == S_LOAD)
        r_blen <= w_blen_calc;
      if (w_burst_done) begin
        r_rd_addr <= r_rd_addr + r_blen;
        r_wr_addr <= r_wr_addr + r_blen;
        r_rem     <= w_rem_dec;
        r_blen    <= w_blen_calc;
      end
    end
  end

  assign bus.oRM_cmd_valid = r_rm_valid;
  assign bus.oRM_cmd_addr  = r_rd_addr;
  assign bus.oRM_cmd_len   = r_blen;
  assign bus.oWM_cmd_valid = r_wm_valid;
  assign bus.oWM_cmd_addr  = r_wr_addr;
  assign bus.oWM_cmd_len   = r_blen;
  assign bus.oBusy         = r_busy;
  assign bus.oWM_done      = r_done;

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Directed bench for dma_burst_sequencer: burst splitting, zero length, stalls, wrap, restart, reset.
module tb_dma_burst_sequencer;

  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rm, n_wm, n_done, n_abd;
  logic [31:0] rm_addr_q [8];
  logic [31:0] rm_len_q  [8];
  logic [31:0] wm_addr_q [8];
  logic [31:0] wm_len_q  [8];

  dma_burst_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  dma_burst_sequencer #(.ADDR_W(ADDR_W), .MAX_BURST(64)) dut (
    .iClk    (clk),
    .iReset_n(rst_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one transfer; acts as RM/WM responder and checks each command against a burst model.
  task automatic run_xfer(input logic [31:0] rd, input logic [31:0] wr, input logic [31:0] len,
                          input int stall, input int abort_burst, input bit hold_go);
    logic [31:0] rem, off, exp_len;
    int pend, tail;
    bit seen_done, abort_arm;
    rem = len & 32'hFFFF_FFFC;
    n_rm = 0; n_wm = 0; n_done = 0; n_abd = 0;
    pend = 0; tail = 0; seen_done = 1'b0; abort_arm = 1'b0;
    @(negedge clk);
    bus.iRM_startaddr = rd;
    bus.iWM_startaddr = wr;
    bus.iLength       = len;
    bus.iStart        = 1'b1;
    for (int cyc = 0; cyc < 400 && tail < 6; cyc++) begin
      @(negedge clk);
      bus.iWM_burst_done = 1'b0;
`ifdef DMA_SEQ_ABORT_EN
      bus.iAbort = 1'b0;
`endif
      if (abort_arm) begin
        abort_arm = 1'b0;
`ifdef DMA_SEQ_ABORT_EN
        bus.iAbort = 1'b1;
`endif
      end
      if (pend == 1) bus.iWM_burst_done = 1'b1;
      if (pend > 0) pend--;

      if (bus.oRM_cmd_valid) begin
        off     = 32'(n_rm) * 32'd64;
        exp_len = (rem - off > 32'd64) ? 32'd64 : rem - off;
        chk("rm_cmd_addr", bus.oRM_cmd_addr, rd + off);
        chk("rm_cmd_len", bus.oRM_cmd_len, exp_len);
        if (stall > 0) begin
          bus.iRM_cmd_ready = 1'b0;
          stall--;
        end else begin
          bus.iRM_cmd_ready = 1'b1;
          if (n_rm < 8) begin
            rm_addr_q[n_rm] = bus.oRM_cmd_addr;
            rm_len_q[n_rm]  = bus.oRM_cmd_len;
          end
          n_rm++;
        end
      end else bus.iRM_cmd_ready = 1'b0;

      if (bus.oWM_cmd_valid) begin
        off     = 32'(n_wm) * 32'd64;
        exp_len = (rem - off > 32'd64) ? 32'd64 : rem - off;
        chk("wm_after_rm_accept", 32'(n_rm > n_wm), 32'd1);
        chk("wm_cmd_addr", bus.oWM_cmd_addr, wr + off);
        chk("wm_cmd_len", bus.oWM_cmd_len, exp_len);
        bus.iWM_cmd_ready = 1'b1;
        if (n_wm < 8) begin
          wm_addr_q[n_wm] = bus.oWM_cmd_addr;
          wm_len_q[n_wm]  = bus.oWM_cmd_len;
        end
        if (n_wm == abort_burst) abort_arm = 1'b1;
        n_wm++;
        pend = 3;
      end else bus.iWM_cmd_ready = 1'b0;

      if (bus.oWM_done) begin
        n_done++;
        seen_done = 1'b1;
        chk("done_busy_low", 32'(bus.oBusy), 32'd0);
`ifdef DMA_SEQ_ABORT_EN
        if (bus.oAborted) n_abd++;
`endif
      end
      if (seen_done) tail++;
    end
    chk("xfer_completed", 32'(seen_done), 32'd1);
    bus.iRM_cmd_ready  = 1'b0;
    bus.iWM_cmd_ready  = 1'b0;
    bus.iWM_burst_done = 1'b0;
`ifdef DMA_SEQ_ABORT_EN
    bus.iAbort = 1'b0;
`endif
    if (!hold_go) bus.iStart = 1'b0;
  endtask

  initial begin
    int  n_bad;
    bit  wm_seen;
    rst_n              = 1'b0;
    bus.iStart         = 1'b0;
    bus.iRM_startaddr  = '0;
    bus.iWM_startaddr  = '0;
    bus.iLength        = '0;
    bus.iRM_cmd_ready  = 1'b0;
    bus.iWM_cmd_ready  = 1'b0;
    bus.iWM_burst_done = 1'b0;
`ifdef DMA_SEQ_ABORT_EN
    bus.iAbort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_rm_valid", 32'(bus.oRM_cmd_valid), 32'd0);
    chk("rst_wm_valid", 32'(bus.oWM_cmd_valid), 32'd0);
    chk("rst_busy", 32'(bus.oBusy), 32'd0);
    chk("rst_done", 32'(bus.oWM_done), 32'd0);
    chk("rst_rm_addr", bus.oRM_cmd_addr, 32'd0);
    chk("rst_wm_len", bus.oWM_cmd_len, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 256 bytes: four 64-byte bursts
    run_xfer(32'h0000_1000, 32'h0000_8000, 32'd256, 0, -1, 1'b0);
    chk("t256_n_rm", 32'(n_rm), 32'd4);
    chk("t256_n_wm", 32'(n_wm), 32'd4);
    chk("t256_n_done", 32'(n_done), 32'd1);
    chk("t256_rm_addr3", rm_addr_q[3], 32'h0000_10C0);
    chk("t256_wm_addr1", wm_addr_q[1], 32'h0000_8040);
    chk("t256_wm_len3", wm_len_q[3], 32'd64);

    // 100 bytes: 64 then 36
    run_xfer(32'h0000_1000, 32'h0000_2000, 32'd100, 0, -1, 1'b0);
    chk("t100_n_rm", 32'(n_rm), 32'd2);
    chk("t100_rm_addr1", rm_addr_q[1], 32'h0000_1040);
    chk("t100_rm_len1", rm_len_q[1], 32'd36);
    chk("t100_wm_len1", wm_len_q[1], 32'd36);
    chk("t100_n_done", 32'(n_done), 32'd1);

    // Zero length: LOAD then DONE, no commands
    @(negedge clk);
    bus.iLength = 32'd0;
    bus.iStart  = 1'b1;
    @(negedge clk);
    chk("z_load_busy", 32'(bus.oBusy), 32'd1);
    chk("z_load_done", 32'(bus.oWM_done), 32'd0);
    chk("z_load_rm_valid", 32'(bus.oRM_cmd_valid), 32'd0);
    @(negedge clk);
    chk("z_done", 32'(bus.oWM_done), 32'd1);
    chk("z_done_busy", 32'(bus.oBusy), 32'd0);
    chk("z_done_rm_valid", 32'(bus.oRM_cmd_valid), 32'd0);
    @(negedge clk);
    chk("z_after_done", 32'(bus.oWM_done), 32'd0);
    chk("z_after_busy", 32'(bus.oBusy), 32'd0);
    bus.iStart = 1'b0;

    // Read master stalls for 5 cycles on a single burst
    run_xfer(32'h0000_2000, 32'h0000_A000, 32'd64, 5, -1, 1'b0);
    chk("stall_n_rm", 32'(n_rm), 32'd1);
    chk("stall_n_wm", 32'(n_wm), 32'd1);
    chk("stall_n_done", 32'(n_done), 32'd1);

`ifdef DMA_SEQ_ABORT_EN
    // Abort while waiting on burst 1: that burst finishes, nothing further is issued
    run_xfer(32'h0000_4000, 32'h0000_9000, 32'd256, 0, 1, 1'b0);
    chk("abort_n_rm", 32'(n_rm), 32'd2);
    chk("abort_n_wm", 32'(n_wm), 32'd2);
    chk("abort_n_done", 32'(n_done), 32'd1);
    chk("abort_flag_at_done", 32'(n_abd), 32'd1);
    chk("abort_flag_held", 32'(bus.oAborted), 32'd1);
`endif

    // Source address wraps on the second burst; GO held high afterwards
    run_xfer(32'hFFFF_FFC0, 32'h0000_3000, 32'd128, 0, -1, 1'b1);
    chk("wrap_n_rm", 32'(n_rm), 32'd2);
    chk("wrap_rm_addr1", rm_addr_q[1], 32'h0000_0000);
    chk("wrap_wm_addr1", wm_addr_q[1], 32'h0000_3040);
    n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.oBusy || bus.oRM_cmd_valid || bus.oWM_done) n_bad++;
    end
    chk("go_held_no_restart", 32'(n_bad), 32'd0);
    bus.iStart = 1'b0;

    // New rising edge restarts; length 7 rounds down to 4
    run_xfer(32'h0000_5000, 32'h0000_6000, 32'd7, 0, -1, 1'b0);
    chk("restart_n_rm", 32'(n_rm), 32'd1);
    chk("restart_len", rm_len_q[0], 32'd4);
    chk("restart_n_done", 32'(n_done), 32'd1);
`ifdef DMA_SEQ_ABORT_EN
    chk("restart_abort_clear", 32'(bus.oAborted), 32'd0);
`endif

    // Reset while the WM command is pending
    @(negedge clk);
    bus.iRM_startaddr = 32'h0000_7000;
    bus.iWM_startaddr = 32'h0000_B000;
    bus.iLength       = 32'd64;
    bus.iStart        = 1'b1;
    bus.iRM_cmd_ready = 1'b1;
    wm_seen = 1'b0;
    for (int i = 0; i < 20 && !wm_seen; i++) begin
      @(negedge clk);
      if (bus.oWM_cmd_valid) wm_seen = 1'b1;
    end
    chk("rstmid_wm_reached", 32'(wm_seen), 32'd1);
    rst_n = 1'b0;
    bus.iRM_cmd_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_wm_valid", 32'(bus.oWM_cmd_valid), 32'd0);
    chk("rstmid_rm_valid", 32'(bus.oRM_cmd_valid), 32'd0);
    chk("rstmid_busy", 32'(bus.oBusy), 32'd0);
    chk("rstmid_done", 32'(bus.oWM_done), 32'd0);
    chk("rstmid_wm_addr", bus.oWM_cmd_addr, 32'd0);
    bus.iStart = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.oWM_done || bus.oBusy) n_bad++;
    end
    chk("rstmid_no_done", 32'(n_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
